// File: rtl/parking_lot_controller_if.sv
// Request/response bundle between the lot sensors/readers and the parking lot controller.
interface parking_lot_controller_if;
    logic       entry_req;
    logic       exit_req;
    logic [2:0] exit_num;
    logic [7:0] occupancy;
    logic [3:0] free_count;
    logic       full;
    logic       entry_grant;
    logic [2:0] entry_space;
    logic       entry_reject;
    logic       exit_ack;
    logic       exit_error;
    logic       gate_open;

    // Sensor / reader side: raises requests, observes the lot state.
    modport master (
        output entry_req,
        output exit_req,
        output exit_num,
        input  occupancy,
        input  free_count,
        input  full,
        input  entry_grant,
        input  entry_space,
        input  entry_reject,
        input  exit_ack,
        input  exit_error,
        input  gate_open
    );

    // Controller side.
    modport slave (
        input  entry_req,
        input  exit_req,
        input  exit_num,
        output occupancy,
        output free_count,
        output full,
        output entry_grant,
        output entry_space,
        output entry_reject,
        output exit_ack,
        output exit_error,
        output gate_open
    );
endinterface

// File: rtl/parking_lot_controller.sv
// Entry/exit sequencer for an 8-space lot: keeps the occupancy map, allocates the lowest
// free space, releases spaces by bit-reversed park number, arbitrates simultaneous
// requests round-robin and times one shared gate.
module parking_lot_controller #(
    parameter int unsigned GATE_CYCLES = 4,
    parameter int unsigned CNT_W       = 4
) (
    input logic                     clk,
    input logic                     rst,
    parking_lot_controller_if.slave bus
);

    localparam logic [1:0] StIdle        = 2'd0;
    localparam logic [1:0] StEntryGate   = 2'd1;
    localparam logic [1:0] StExitGate    = 2'd2;
    localparam logic [1:0] StWaitRelease = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             ptr_exit_q, ptr_exit_d;       // 1: exit wins the next tie
    logic             served_exit_q, served_exit_d; // which request WAIT_RELEASE watches
    logic [7:0]       occ_q, occ_d;
    logic [3:0]       free_q, free_d;
    logic             full_q, full_d;
    logic [2:0]       space_q, space_d;
    logic             grant_q, grant_d;
    logic             reject_q, reject_d;
    logic             ack_q, ack_d;
    logic             error_q, error_d;

    logic [2:0]       exit_idx;
    logic [2:0]       free_idx;
    logic             serve_entry;
    logic             serve_exit;
    logic             served_req;
    logic [3:0]       pop;

    // Exit readers number spaces bit-reversed relative to the occupancy map.
    assign exit_idx = {bus.exit_num[0], bus.exit_num[1], bus.exit_num[2]};

    // Lowest-index free space; scanning downward lets the lowest index win.
    always_comb begin
        free_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (!occ_q[i]) begin
                free_idx = 3'(i);
            end
        end
    end

    // Round-robin selection between entry and exit, only meaningful in IDLE.
    always_comb begin
        serve_entry = bus.entry_req && (!bus.exit_req || !ptr_exit_q);
        serve_exit  = bus.exit_req && (!bus.entry_req || ptr_exit_q);
        served_req  = served_exit_q ? bus.exit_req : bus.entry_req;
    end

    // Next-state logic for the FSM, occupancy map and response pulses.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        ptr_exit_d    = ptr_exit_q;
        served_exit_d = served_exit_q;
        occ_d         = occ_q;
        space_d       = space_q;
        grant_d       = 1'b0;
        reject_d      = 1'b0;
        ack_d         = 1'b0;
        error_d       = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.entry_req && bus.exit_req) begin
                    ptr_exit_d = !ptr_exit_q;
                end
                if (serve_entry) begin
                    served_exit_d = 1'b0;
                    if (full_q) begin
                        reject_d = 1'b1;
                        state_d  = StWaitRelease;
                    end else begin
                        occ_d[free_idx] = 1'b1;
                        space_d         = free_idx;
                        grant_d         = 1'b1;
                        timer_d         = CNT_W'(GATE_CYCLES);
                        state_d         = StEntryGate;
                    end
                end else if (serve_exit) begin
                    served_exit_d = 1'b1;
                    if (occ_q[exit_idx]) begin
                        occ_d[exit_idx] = 1'b0;
                        ack_d           = 1'b1;
                        timer_d         = CNT_W'(GATE_CYCLES);
                        state_d         = StExitGate;
                    end else begin
                        error_d = 1'b1;
                        state_d = StWaitRelease;
                    end
                end
            end
            StEntryGate, StExitGate: begin
                timer_d = timer_q - CNT_W'(1);
                if (timer_q <= CNT_W'(1)) begin
                    state_d = StWaitRelease;
                end
            end
            StWaitRelease: begin
                // Hold off until the served level drops so it is not served twice.
                if (!served_req) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Free count and full flag track the next occupancy so they move on the same edge.
    always_comb begin
        pop = 4'd0;
        for (int i = 0; i < 8; i++) begin
            pop = pop + {3'd0, occ_d[i]};
        end
        free_d = 4'd8 - pop;
        full_d = (occ_d == 8'hFF);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            timer_q       <= '0;
            ptr_exit_q    <= 1'b1;
            served_exit_q <= 1'b0;
            occ_q         <= 8'h00;
            free_q        <= 4'd8;
            full_q        <= 1'b0;
            space_q       <= 3'd0;
            grant_q       <= 1'b0;
            reject_q      <= 1'b0;
            ack_q         <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            ptr_exit_q    <= ptr_exit_d;
            served_exit_q <= served_exit_d;
            occ_q         <= occ_d;
            free_q        <= free_d;
            full_q        <= full_d;
            space_q       <= space_d;
            grant_q       <= grant_d;
            reject_q      <= reject_d;
            ack_q         <= ack_d;
            error_q       <= error_d;
        end
    end

    assign bus.occupancy    = occ_q;
    assign bus.free_count   = free_q;
    assign bus.full         = full_q;
    assign bus.entry_grant  = grant_q;
    assign bus.entry_space  = space_q;
    assign bus.entry_reject = reject_q;
    assign bus.exit_ack     = ack_q;
    assign bus.exit_error   = error_q;
    // Decoded from state so an asynchronous reset drops the gate immediately.
    assign bus.gate_open    = (state_q == StEntryGate) || (state_q == StExitGate);

endmodule

// File: tb/tb_parking_lot_controller.sv
// Bench for parking_lot_controller: directed vector table, hand-written arbitration and
// reset sequences, then random transactions checked against a transaction-level model.
module tb_parking_lot_controller;

    localparam int unsigned GATE = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    parking_lot_controller_if bus ();

    parking_lot_controller #(
        .GATE_CYCLES(GATE),
        .CNT_W      (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [3:0] pulses;  // {grant, reject, ack, error}
        logic [2:0] space;
        logic [7:0] occ;
        logic [3:0] fc;
        logic       fl;
        int         gate;    // gate_open cycles seen for this response
        bit         extra;   // a further pulse seen while watching
    } resp_t;

    typedef struct {
        bit         is_entry;
        logic [2:0] num;
        logic [3:0] pulses;
        logic [2:0] space;
        logic [7:0] occ;
        logic [3:0] fc;
        logic       fl;
        int         gate;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] m_occ;
    logic [2:0] m_space;
    bit         m_ptr_exit;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] pulses_now();
        return {bus.entry_grant, bus.entry_reject, bus.exit_ack, bus.exit_error};
    endfunction

    task automatic wait_resp(input string tag, output resp_t r);
        bit got = 0;
        int n = 0;
        r.pulses = 4'd0; r.space = 3'd0; r.occ = 8'd0; r.fc = 4'd0; r.fl = 1'b0;
        r.gate = 0; r.extra = 1'b0;
        while (!got && n < 40) begin
            tick();
            n++;
            if (pulses_now() != 4'd0) begin
                got      = 1;
                r.pulses = pulses_now();
                r.space  = bus.entry_space;
                r.occ    = bus.occupancy;
                r.fc     = bus.free_count;
                r.fl     = bus.full;
                r.gate   = bus.gate_open ? 1 : 0;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no response pulse in 40 cycles, one required", tag);
        end
    endtask

    // Watch the cycles after a response: count gate cycles and any stray pulse.
    task automatic watch(inout resp_t r);
        int len = (r.pulses[3] || r.pulses[1]) ? int'(GATE) : 1;
        for (int i = 0; i < len; i++) begin
            tick();
            if (bus.gate_open) r.gate++;
            if (pulses_now() != 4'd0) r.extra = 1'b1;
        end
    endtask

    task automatic run_single(input bit is_entry, input logic [2:0] num, output resp_t r);
        bus.exit_num  = num;
        bus.entry_req = is_entry;
        bus.exit_req  = !is_entry;
        wait_resp("single", r);
        bus.entry_req = 1'b0;
        bus.exit_req  = 1'b0;
        watch(r);
        tick();
        tick();
    endtask

    task automatic run_pair(input logic [2:0] num, output resp_t r1, output resp_t r2,
                            output bit first_entry);
        bus.exit_num  = num;
        bus.entry_req = 1'b1;
        bus.exit_req  = 1'b1;
        wait_resp("pair first", r1);
        first_entry = r1.pulses[3] || r1.pulses[2];
        if (first_entry) bus.entry_req = 1'b0;
        else             bus.exit_req  = 1'b0;
        watch(r1);
        wait_resp("pair second", r2);
        bus.entry_req = 1'b0;
        bus.exit_req  = 1'b0;
        watch(r2);
        tick();
        tick();
    endtask

    // Serve one request in the model: lowest free space on entry, reversed index on exit.
    function automatic resp_t model_serve(input bit is_entry, input logic [2:0] num);
        resp_t e;
        int    cnt = 0;
        int    idx;
        bit    found = 0;
        e.extra = 1'b0;
        e.gate  = 0;
        if (is_entry) begin
            for (int i = 0; i < 8; i++) begin
                if (!found && !m_occ[i]) begin
                    found    = 1;
                    m_occ[i] = 1'b1;
                    m_space  = 3'(i);
                end
            end
            e.pulses = found ? 4'b1000 : 4'b0100;
            e.gate   = found ? int'(GATE) : 0;
        end else begin
            idx = 4 * int'(num[0]) + 2 * int'(num[1]) + int'(num[2]);
            if (m_occ[idx]) begin
                m_occ[idx] = 1'b0;
                e.pulses   = 4'b0010;
                e.gate     = int'(GATE);
            end else begin
                e.pulses = 4'b0001;
            end
        end
        for (int i = 0; i < 8; i++) cnt += int'(m_occ[i]);
        e.space = m_space;
        e.occ   = m_occ;
        e.fc    = 4'(8 - cnt);
        e.fl    = (cnt == 8);
        return e;
    endfunction

    task automatic compare(input string tag, input resp_t a, input resp_t e);
        check({tag, " pulses"}, 32'(a.pulses), 32'(e.pulses));
        check({tag, " entry_space"}, 32'(a.space), 32'(e.space));
        check({tag, " occupancy"}, 32'(a.occ), 32'(e.occ));
        check({tag, " free_count"}, 32'(a.fc), 32'(e.fc));
        check({tag, " full"}, 32'(a.fl), 32'(e.fl));
        check({tag, " gate cycles"}, 32'(a.gate), 32'(e.gate));
        check({tag, " extra pulse"}, 32'(a.extra), 32'(e.extra));
    endtask

    function automatic resp_t mk(input logic [3:0] p, input logic [2:0] s, input logic [7:0] o,
                                 input logic [3:0] f, input logic fl, input int g);
        resp_t r;
        r.pulses = p; r.space = s; r.occ = o; r.fc = f; r.fl = fl; r.gate = g; r.extra = 1'b0;
        return r;
    endfunction

    vec_t  tbl[21];
    resp_t r, r1, r2, e, e1, e2;
    bit    first_entry;

    initial begin
        // Directed table: fill the lot, reject, swap space 4, drain to 8'h01, error, empty.
        for (int i = 0; i < 8; i++) begin
            tbl[i] = '{1'b1, 3'd0, 4'b1000, 3'(i), 8'((1 << (i + 1)) - 1), 4'(7 - i),
                       (i == 7), int'(GATE)};
        end
        tbl[8]  = '{1'b1, 3'b000, 4'b0100, 3'd7, 8'hFF, 4'd0, 1'b1, 0};
        tbl[9]  = '{1'b0, 3'b001, 4'b0010, 3'd7, 8'hEF, 4'd1, 1'b0, int'(GATE)};
        tbl[10] = '{1'b1, 3'b000, 4'b1000, 3'd4, 8'hFF, 4'd0, 1'b1, int'(GATE)};
        tbl[11] = '{1'b0, 3'b111, 4'b0010, 3'd4, 8'h7F, 4'd1, 1'b0, int'(GATE)};
        tbl[12] = '{1'b0, 3'b011, 4'b0010, 3'd4, 8'h3F, 4'd2, 1'b0, int'(GATE)};
        tbl[13] = '{1'b0, 3'b101, 4'b0010, 3'd4, 8'h1F, 4'd3, 1'b0, int'(GATE)};
        tbl[14] = '{1'b0, 3'b001, 4'b0010, 3'd4, 8'h0F, 4'd4, 1'b0, int'(GATE)};
        tbl[15] = '{1'b0, 3'b110, 4'b0010, 3'd4, 8'h07, 4'd5, 1'b0, int'(GATE)};
        tbl[16] = '{1'b0, 3'b010, 4'b0010, 3'd4, 8'h03, 4'd6, 1'b0, int'(GATE)};
        tbl[17] = '{1'b0, 3'b100, 4'b0010, 3'd4, 8'h01, 4'd7, 1'b0, int'(GATE)};
        tbl[18] = '{1'b0, 3'b100, 4'b0001, 3'd4, 8'h01, 4'd7, 1'b0, 0};
        tbl[19] = '{1'b0, 3'b000, 4'b0010, 3'd4, 8'h00, 4'd8, 1'b0, int'(GATE)};
        tbl[20] = '{1'b0, 3'b000, 4'b0001, 3'd4, 8'h00, 4'd8, 1'b0, 0};

        bus.entry_req = 1'b0;
        bus.exit_req  = 1'b0;
        bus.exit_num  = 3'd0;
        rst = 1'b1;
        #2;
        check("reset occupancy", 32'(bus.occupancy), 32'h00);
        check("reset free_count", 32'(bus.free_count), 32'd8);
        check("reset full", 32'(bus.full), 32'd0);
        check("reset pulses", 32'(pulses_now()), 32'd0);
        check("reset entry_space", 32'(bus.entry_space), 32'd0);
        check("reset gate_open", 32'(bus.gate_open), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_occ = 8'h00; m_space = 3'd0; m_ptr_exit = 1'b1;
        tick();

        for (int i = 0; i < 21; i++) begin
            run_single(tbl[i].is_entry, tbl[i].num, r);
            e = model_serve(tbl[i].is_entry, tbl[i].num);
            compare($sformatf("vec%0d", i), r,
                    mk(tbl[i].pulses, tbl[i].space, tbl[i].occ, tbl[i].fc, tbl[i].fl,
                       tbl[i].gate));
        end

        // Simultaneous requests: exit wins first after reset, then entry wins the next tie.
        run_single(1'b1, 3'd0, r);
        compare("pre-pair entry", r, mk(4'b1000, 3'd0, 8'h01, 4'd7, 1'b0, int'(GATE)));
        run_pair(3'b000, r1, r2, first_entry);
        check("pair1 exit first", 32'(first_entry), 32'd0);
        compare("pair1 first", r1, mk(4'b0010, 3'd0, 8'h00, 4'd8, 1'b0, int'(GATE)));
        compare("pair1 second", r2, mk(4'b1000, 3'd0, 8'h01, 4'd7, 1'b0, int'(GATE)));
        run_pair(3'b000, r1, r2, first_entry);
        check("pair2 entry first", 32'(first_entry), 32'd1);
        compare("pair2 first", r1, mk(4'b1000, 3'd1, 8'h03, 4'd6, 1'b0, int'(GATE)));
        compare("pair2 second", r2, mk(4'b0010, 3'd1, 8'h02, 4'd7, 1'b0, int'(GATE)));

        // Asynchronous reset in the second cycle of an exit gate.
        bus.exit_num = 3'b100;
        bus.exit_req = 1'b1;
        wait_resp("reset-gate exit", r);
        check("reset-gate ack", 32'(r.pulses), 32'b0010);
        bus.exit_req = 1'b0;
        tick();
        check("reset-gate gate cycle 2", 32'(bus.gate_open), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("async reset gate_open", 32'(bus.gate_open), 32'd0);
        check("async reset occupancy", 32'(bus.occupancy), 32'h00);
        check("async reset free_count", 32'(bus.free_count), 32'd8);
        check("async reset full", 32'(bus.full), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        m_occ = 8'h00; m_space = 3'd0; m_ptr_exit = 1'b1;
        tick();

        // Random transactions against the model.
        for (int t = 0; t < 120; t++) begin
            int          kind = int'($urandom_range(0, 5));
            logic [2:0]  num  = 3'($urandom_range(0, 7));
            bit          exp_first;
            if (kind <= 2) begin
                run_single(1'b1, num, r);
                e = model_serve(1'b1, num);
                compare($sformatf("rand%0d entry", t), r, e);
            end else if (kind <= 4) begin
                run_single(1'b0, num, r);
                e = model_serve(1'b0, num);
                compare($sformatf("rand%0d exit", t), r, e);
            end else begin
                run_pair(num, r1, r2, first_entry);
                exp_first  = !m_ptr_exit;
                m_ptr_exit = !m_ptr_exit;
                e1 = model_serve(exp_first, num);
                e2 = model_serve(!exp_first, num);
                check($sformatf("rand%0d pair order", t), 32'(first_entry), 32'(exp_first));
                compare($sformatf("rand%0d pair first", t), r1, e1);
                compare($sformatf("rand%0d pair second", t), r2, e2);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/parking_lot_controller.md
Name: parking_lot_controller

Overview:
Sequences entry and exit of cars for the 8-space lot. It keeps the registered occupancy map and allocates the lowest free space on entry. On exit it releases the space named by a 3-bit park number, using the same bit-reversed one-hot decode as the exit decoder. It arbitrates simultaneous entry/exit requests and times a single shared gate.

Parameters:
GATE_CYCLES, 4, number of clk cycles gate_open stays high per served car (legal 1..15)
CNT_W, 4, width of gate timer counter (must hold GATE_CYCLES)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
entry_req  input  1  level request from entry sensor; held until entry_grant or entry_reject seen
exit_req  input  1  level request from exit reader; held until exit_ack or exit_error seen
exit_num  input  3  park number of leaving car; valid while exit_req high
occupancy  output  8  registered one-hot-per-space map; bit i = space i occupied
free_count  output  4  registered count of free spaces, 0..8
full  output  1  registered, high when occupancy == 8'hFF
entry_grant  output  1  1-cycle pulse: entry accepted
entry_space  output  3  allocated space index; valid in the entry_grant cycle, held until next grant
entry_reject  output  1  1-cycle pulse: entry refused (lot full)
exit_ack  output  1  1-cycle pulse: exit accepted, space freed
exit_error  output  1  1-cycle pulse: exit_num names an empty space
gate_open  output  1  gate drive, high for GATE_CYCLES cycles per accepted car

Behaviour:
- Reset (async, any state): state=IDLE; occupancy=0; free_count=8; full=0; all pulses=0; entry_space=0; gate_open=0; timer=0; priority pointer=EXIT.
- Space index mapping for exit: idx = {exit_num[0], exit_num[1], exit_num[2]} (bit-reversed). Example: exit_num=3'b001 -> idx 4; 3'b011 -> idx 6.
- FSM states: IDLE, ENTRY_GATE, EXIT_GATE, WAIT_RELEASE.
- IDLE: requests are sampled only here. If only one is high, serve it. If both are high, serve the one selected by the priority pointer, then toggle the pointer to the other requester. The pointer does not change when only one request is present.
- Entry serve, not full:
  - same edge: set occupancy bit of the lowest-index free space
  - entry_space <= that index; entry_grant pulses for 1 cycle
  - timer <= GATE_CYCLES; go to ENTRY_GATE
- Entry serve, full: entry_reject pulses for 1 cycle; occupancy unchanged; no gate; go to WAIT_RELEASE.
- Exit serve, occupancy[idx]=1:
  - clear the bit; exit_ack pulses for 1 cycle
  - timer <= GATE_CYCLES; go to EXIT_GATE
- Exit serve, occupancy[idx]=0: exit_error pulses for 1 cycle; no change; go to WAIT_RELEASE.
- ENTRY_GATE / EXIT_GATE:
  - gate_open=1 in every cycle of the state; timer decrements each cycle
  - when timer reaches 1, next state is WAIT_RELEASE
  - gate_open is high for exactly GATE_CYCLES cycles, starting the cycle after the grant/ack edge
  - new requests are ignored while the gate is open
- WAIT_RELEASE: stay until the served request is low, then go to IDLE. Protects against double service of a held level. The unserved request stays pending and is served from IDLE.
- free_count and full are registered and update on the same edge as the occupancy change. Invariant: free_count = 8 - popcount(occupancy).
- Latency: request high in IDLE -> grant/ack/reject/error pulse on the next rising edge.
- exit_num is sampled only on the serving edge; changes at other times have no effect.
- Async reset mid-gate forces gate_open=0 immediately and clears all occupancy.

Test Plan:
- Reset, then 8 sequential entries (each req held until grant, then dropped) -> entry_space 0,1,...,7; free_count 7..0; full=1 after the 8th; gate_open high 4 cycles each.
- Lot full, entry_req -> entry_reject 1-cycle pulse, no gate_open, occupancy stays 8'hFF.
- Occupancy 8'hFF, exit_num=3'b001 -> exit_ack, occupancy 8'hEF (idx 4 freed). Then entry_req -> entry_space=4, occupancy 8'hFF.
- Occupancy 8'h01, exit_num=3'b100 (idx 1, empty) -> exit_error pulse, occupancy unchanged, no gate.
- From reset, entry_req and exit_req (exit_num=3'b000, occupancy 8'h01) raised together:
  - exit is served first (ack, occupancy 8'h00)
  - after release, entry is served (grant, space 0)
  - next simultaneous pair is served entry-first
- Assert rst during EXIT_GATE, cycle 2 -> gate_open=0 and occupancy=0 without a clock edge; free_count=8.
